// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types and helpers for the round key XOR engine
// Provides: round_idx_t, fsm_state_t, layout_t, beats(), byte_of().
package aes_key_pkg;

  localparam int NR_MAX = 14;

  typedef logic [$clog2(NR_MAX+1)-1:0] round_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

  typedef enum logic {DIRECT, XPOSE} layout_t;

  // Number of RUN cycles needed to cover the four 32-bit words.
  function automatic int beats(input int lanes);
    return 4 / lanes;
  endfunction

  // State byte k occupies bits [8k+7:8k].
  function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
    return s[8*k +: 8];
  endfunction

endpackage

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - NR+1 x 128-bit round key register array
// Ports: CLK, RESET (sync, active-high, clears all slots);
//        we/waddr/wdata write port (addresses above NR ignored);
//        raddr/rdata combinational read (addresses above NR read as zero).
module round_key_store #(
  parameter int NR = 10,
  parameter int AW = $clog2(NR+1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [NR+1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i <= NR; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= AW'(NR))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= AW'(NR)) ? mem[raddr] : '0;

endmodule

// File: rtl/round_key_xor_engine.sv
// rtl/round_key_xor_engine.sv - sequential AddRoundKey stage with internal key schedule
// Ports: CLK, RESET (sync, active-high); key_we/key_waddr/key_wdata key store write;
//        in_valid/in_ready/in_state/in_round/in_inv/in_xpose request;
//        out_valid/out_ready/out_state/out_err result; busy (FSM not idle).
module round_key_xor_engine
  import aes_key_pkg::*;
#(
  parameter int NR    = 10,
  parameter int LANES = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      key_we,
  input  logic [$clog2(NR+1)-1:0]   key_waddr,
  input  logic [127:0]              key_wdata,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              in_state,
  input  logic [$clog2(NR+1)-1:0]   in_round,
  input  logic                      in_inv,
  input  logic                      in_xpose,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              out_state,
  output logic                      out_err,
  output logic                      busy
);

  localparam int AW    = $clog2(NR+1);
  localparam int BEATS = beats(LANES);

  fsm_state_t   state_q;
  logic [127:0] work_q;
  logic [127:0] work_next;
  logic [127:0] key_q;
  logic         err_q;
  layout_t      layout_q;
  logic [1:0]   beat_q;

  logic          req_err;
  logic [AW-1:0] slot;
  logic [127:0]  rdata;
  logic [127:0]  key_sel;

  // Out-of-range rounds are flagged in both modes; the inverse subtraction is
  // only meaningful when in_round <= NR, so the zero key covers the rest.
  assign req_err = (in_round > AW'(NR));
  assign slot    = in_inv ? (AW'(NR) - in_round) : in_round;
  assign key_sel = req_err ? '0 : rdata;

  round_key_store #(.NR(NR), .AW(AW)) u_store (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (key_we),
    .waddr (key_waddr),
    .wdata (key_wdata),
    .raddr (slot),
    .rdata (rdata)
  );

  // Word w is handled on beat w/LANES. Transposed layout scatters key byte j
  // of word w (j=0 is the word MSB) onto state byte 4j+w.
  always_comb begin
    work_next = work_q;
    for (int w = 0; w < 4; w++) begin
      if ((w / LANES) == int'(beat_q)) begin
        if (layout_q == DIRECT) begin
          work_next[32*w +: 32] = work_q[32*w +: 32] ^ key_q[32*w +: 32];
        end else begin
          for (int j = 0; j < 4; j++) begin
            work_next[8*(4*j+w) +: 8] = byte_of(work_q, 4*j+w) ^ byte_of(key_q, 4*w+3-j);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      work_q   <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
      layout_q <= DIRECT;
      beat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q   <= in_state;
            key_q    <= key_sel;
            err_q    <= req_err;
            layout_q <= in_xpose ? XPOSE : DIRECT;
            beat_q   <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          work_q <= work_next;
          if (beat_q == 2'(BEATS-1)) begin
            state_q <= DONE;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_round_key_xor_engine.sv
// tb/tb_round_key_xor_engine.sv - directed self-checking bench for round_key_xor_engine
module tb_round_key_xor_engine;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KX   = 128'h03070b0f02060a0e0105090d0004080c;
  localparam logic [127:0] PAT  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] NPAT = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] K1   = 128'h11111111222222223333333344444444;
  localparam logic [127:0] K1B  = {16{8'ha5}};

  logic         clk = 1'b0;
  logic         reset;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic         in_valid;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         in_inv;
  logic         in_xpose;
  logic         out_ready;

  logic         in_ready1, out_valid1, out_err1, busy1;
  logic [127:0] out_state1;
  logic         in_ready4, out_valid4, out_err4, busy4;
  logic [127:0] out_state4;

  int checks = 0;
  int errors = 0;

  int           lat1, lat4;
  logic [127:0] res1, res4;
  logic         err1;

  always #5 clk = ~clk;

  round_key_xor_engine #(.NR(10), .LANES(1)) dut (
    .CLK(clk), .RESET(reset), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready1), .in_state(in_state), .in_round(in_round),
    .in_inv(in_inv), .in_xpose(in_xpose), .out_valid(out_valid1), .out_ready(out_ready),
    .out_state(out_state1), .out_err(out_err1), .busy(busy1)
  );

  round_key_xor_engine #(.NR(10), .LANES(4)) dut4 (
    .CLK(clk), .RESET(reset), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready4), .in_state(in_state), .in_round(in_round),
    .in_inv(in_inv), .in_xpose(in_xpose), .out_valid(out_valid4), .out_ready(out_ready),
    .out_state(out_state4), .out_err(out_err4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [127:0] d);
    key_we = 1'b1; key_waddr = a; key_wdata = d;
    tick();
    key_we = 1'b0;
  endtask

  // One operation with out_ready=1; an optional key write shares the accept cycle.
  task automatic op(input logic [127:0] s, input logic [3:0] r, input logic inv, input logic x,
                    input logic we, input logic [3:0] wa, input logic [127:0] wd);
    int n;
    in_state = s; in_round = r; in_inv = inv; in_xpose = x; in_valid = 1'b1;
    key_we = we; key_waddr = wa; key_wdata = wd;
    tick();
    in_valid = 1'b0; key_we = 1'b0;
    n = 1; lat1 = 0; lat4 = 0; res1 = 'x; res4 = 'x; err1 = 1'bx;
    while (lat1 == 0 && n < 40) begin
      if (out_valid4 && lat4 == 0) begin
        lat4 = n; res4 = out_state4;
      end
      if (out_valid1) begin
        lat1 = n; res1 = out_state1; err1 = out_err1;
      end else begin
        tick();
        n++;
      end
    end
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_state = '0; in_round = '0; in_inv = 1'b0; in_xpose = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_in_ready", 128'(in_ready1), 128'(1));
    chk("rst_out_valid", 128'(out_valid1), 128'(0));
    chk("rst_out_state", out_state1, '0);
    chk("rst_out_err", 128'(out_err1), 128'(0));
    chk("rst_busy", 128'(busy1), 128'(0));

    // direct layout
    wr(4'd0, K0);
    op('0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("direct_state", res1, K0);
    chk("direct_err", 128'(err1), 128'(0));
    chk("direct_lat", 128'(lat1), 128'(5));
    chk("direct_state_l4", res4, K0);
    chk("direct_lat_l4", 128'(lat4), 128'(2));

    // transposed layout
    op('0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, '0);
    chk("xpose_state", res1, KX);
    chk("xpose_lat", 128'(lat1), 128'(5));
    chk("xpose_state_l4", res4, KX);
    chk("xpose_lat_l4", 128'(lat4), 128'(2));

    // inverse indexing
    wr(4'd10, ONES);
    wr(4'd0, '0);
    op(PAT, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk("inv_r0", res1, NPAT);
    op(PAT, 4'd10, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk("inv_r10", res1, PAT);

    // backpressure with a mid-RUN rewrite of the in-use slot
    wr(4'd1, K1);
    out_ready = 1'b0;
    in_state = '0; in_round = 4'd1; in_inv = 1'b0; in_xpose = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    key_we = 1'b1; key_waddr = 4'd1; key_wdata = K1B;
    tick();
    key_we = 1'b0;
    n = 0;
    while (!out_valid1 && n < 40) begin
      tick();
      n++;
    end
    chk("bp_valid", 128'(out_valid1), 128'(1));
    chk("bp_old_key", out_state1, K1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_hold_valid", 128'(out_valid1), 128'(1));
      chk("bp_hold_state", out_state1, K1);
      chk("bp_hold_in_ready", 128'(in_ready1), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 128'(out_valid1), 128'(0));
    chk("bp_release_in_ready", 128'(in_ready1), 128'(1));
    op('0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, '0);
    chk("hazard_new_key_same_cycle_old", res1, K1B);
    op('0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("hazard_after_write", res1, '0);

    // out-of-range round and ignored write
    op(PAT, 4'd11, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("err_fwd_flag", 128'(err1), 128'(1));
    chk("err_fwd_state", res1, PAT);
    op(PAT, 4'd11, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    chk("err_inv_flag", 128'(err1), 128'(1));
    chk("err_inv_state", res1, PAT);
    wr(4'd11, K1B);
    op('0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("bad_waddr_slot0", res1, '0);
    chk("bad_waddr_err", 128'(err1), 128'(0));
    op('0, 4'd10, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("bad_waddr_slot10", res1, ONES);

    // reset during beat 2
    wr(4'd0, K0);
    in_state = '0; in_round = 4'd0; in_inv = 1'b0; in_xpose = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("midrun_busy", 128'(busy1), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 128'(out_valid1), 128'(0));
    chk("midrst_in_ready", 128'(in_ready1), 128'(1));
    chk("midrst_busy", 128'(busy1), 128'(0));
    op('0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    chk("midrst_slot0_cleared", res1, '0);
    chk("midrst_lat", 128'(lat1), 128'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_xor_engine.md
Name: round_key_xor_engine

Overview:
- Parametrised, sequential successor to the single-cycle AddRoundKey/InvAddRoundKey XOR stage of the AES core.
- Holds the expanded key schedule (NR+1 round keys) in an internal register store, loaded via a write port.
- Accepts a 128-bit state plus round index over a valid/ready handshake and XORs in the selected round key, LANES 32-bit words per cycle.
- Supports forward or inverse round indexing, and direct or transposed (column-major state / row-word key) byte layout, selectable per operation.

Parameters:
- NR, 10, number of AES rounds; the store holds NR+1 keys (10/12/14 legal).
- LANES, 1, 32-bit words processed per cycle; legal 1, 2, 4; BEATS = 4/LANES.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- key_we  in  1  write enable for the key store
- key_waddr  in  $clog2(NR+1)  key slot index
- key_wdata  in  128  round key; word w = bits [32w+31:32w], byte j=0 is the word MSB
- in_valid  in  1  operation request
- in_ready  out  1  engine can accept
- in_state  in  128  state to be keyed
- in_round  in  $clog2(NR+1)  round number
- in_inv  in  1  1: key slot = NR - in_round; 0: key slot = in_round
- in_xpose  in  1  1: transposed layout; 0: direct layout
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_state  out  128  keyed state
- out_err  out  1  qualified by out_valid; round index was out of range
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (one CLK edge with RESET=1):
  - FSM to IDLE; in_ready=1; out_valid=0; out_state=0; out_err=0; busy=0.
  - All key slots cleared to 0.
  - An in-flight operation is discarded with no output.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_state into the work register; latch the selected key slot (store read before any same-cycle write); latch in_xpose; clear the beat counter; go to RUN.
  - If the computed slot > NR (in_round > NR, both modes): latch err=1 and use key 0 (state passes through unchanged).
- RUN:
  - in_ready=0.
  - Beat b (0..BEATS-1) XORs key words w = b*LANES .. b*LANES+LANES-1 into the work register.
  - Direct mode: key word w XORs state bits [32w+31:32w].
  - Transposed mode: key byte j of word w XORs state byte 4j+w (state byte k = bits [8k+7:8k]).
  - After beat BEATS-1: go to DONE.
- DONE:
  - out_valid=1; out_state = work register; out_err = latched err.
  - Outputs hold stable until out_ready=1, then next cycle is IDLE with out_valid=0.
- Latency: accept edge, then BEATS RUN cycles; out_valid rises BEATS+1 cycles after the accept edge. Throughput: one operation per BEATS+2 cycles minimum.
- Key writes:
  - Allowed in any state and take effect on the next edge.
  - Never alter an in-flight operation (key latched at accept).
  - A write to the slot being accepted in the same cycle: the old key is used.
  - key_waddr > NR: write ignored.
- out_ready while out_valid=0 has no effect; in_valid outside IDLE is ignored (in_ready=0).
- The XOR is purely bitwise, with no carries; width is fixed at 128.

Decomposition:
- Package aes_key_pkg holds:
  - the round_idx_t typedef (width $clog2(NR_MAX+1), NR_MAX=14);
  - the fsm_state_t enum {IDLE, RUN, DONE};
  - the layout enum {DIRECT, XPOSE};
  - a beats(LANES) constant function;
  - the byte_of(state, k) helper.
- One sub-module, round_key_store: NR+1 x 128 register array with reset clear, one write port, and a combinational read.

Test Plan:
- Key mode, direct: write slot 0 = 0x000102030405060708090a0b0c0d0e0f; op state=0, round=0, inv=0, xpose=0 -> out_state 0x000102030405060708090a0b0c0d0e0f, out_err=0, out_valid exactly 5 cycles after accept (LANES=1).
- Transposed layout: same key, xpose=1 -> out_state 0x03070b0f02060a0e0105090d0004080c; repeat with LANES=4 -> same value, out_valid 2 cycles after accept.
- Inverse indexing: slot 10 = all 0xFF, slot 0 = 0; op round=0, inv=1, state=0x0123...cdef pattern -> out_state = bitwise NOT of the input; round=10, inv=1 -> out_state unchanged.
- Backpressure and key hazard: hold out_ready=0 for 7 cycles -> out_state/out_valid stable, in_ready=0; rewrite the in-use slot mid-RUN -> result uses the old key; the next op uses the new key.
- Error: round=11 with NR=10 -> out_err=1, out_state = in_state; waddr=11 write -> all slots unchanged.
- Reset mid-RUN: assert RESET at beat 2 -> next cycle out_valid=0, in_ready=1, busy=0; a subsequent read of slot 0 with state=0 yields 0.
